cv32e40p_sleep_sequencer: RTL

Sequences the core's entry into and exit from WFI sleep.
- Takes a sleep request from the controller and waits for IF/LSU/APU/controller activity to drain.
- Applies a settle window, then drops the enable for the core's main clock gate.
- On a wake or debug event, re-enables the clock and holds the core through a wake-up latency before releasing it.
- Sits between cv32e40p_controller and the core clock gate; it is the single owner of the gate enable.

---
 rtl/cv32e40p_sleep_sequencer_if.sv | 29 ++
 rtl/cv32e40p_sleep_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cv32e40p_sleep_sequencer_if.sv
// Signal bundle between controller/clock gate (master) and the sleep sequencer (slave).
interface cv32e40p_sleep_sequencer_if;
    logic fetch_enable_i;
    logic sleep_req_i;
    logic if_busy_i;
    logic ctrl_busy_i;
    logic lsu_busy_i;
    logic apu_busy_i;
    logic wake_i;
    logic debug_req_i;
    logic clock_en_o;
    logic core_sleep_o;
    logic fetch_enable_o;
    logic sleep_abort_o;
    logic drain_timeout_o;
    logic wake_o;

    modport slave (
        input  fetch_enable_i, sleep_req_i, if_busy_i, ctrl_busy_i, lsu_busy_i, apu_busy_i,
        input  wake_i, debug_req_i,
        output clock_en_o, core_sleep_o, fetch_enable_o, sleep_abort_o, drain_timeout_o, wake_o
    );

    modport master (
        output fetch_enable_i, sleep_req_i, if_busy_i, ctrl_busy_i, lsu_busy_i, apu_busy_i,
        output wake_i, debug_req_i,
        input  clock_en_o, core_sleep_o, fetch_enable_o, sleep_abort_o, drain_timeout_o, wake_o
    );
endinterface

// File: rtl/cv32e40p_sleep_sequencer.sv
// WFI sleep sequencer: drains the core, gates its clock, and restores it on wake/debug.
// Build macro CV32E40P_SLEEP_STATS_EN adds sleep cycle and sleep entry statistics outputs.
module cv32e40p_sleep_sequencer #(
    parameter int unsigned DRAIN_TIMEOUT = 64,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned WAKE_CYCLES   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
`ifdef CV32E40P_SLEEP_STATS_EN
    output logic [31:0]               sleep_cycles_o,
    output logic [15:0]               sleep_count_o,
`endif
    cv32e40p_sleep_sequencer_if.slave bus
);
    localparam int unsigned MaxDs     = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT
                                                                         : SETTLE_CYCLES;
    localparam int unsigned CntMax    = (MaxDs > WAKE_CYCLES) ? MaxDs : WAKE_CYCLES;
    localparam int unsigned CntW      = $clog2(CntMax + 1);
    localparam int unsigned WakeLen   = (WAKE_CYCLES == 0) ? 1 : WAKE_CYCLES;
    localparam int unsigned SettleLen = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;

    localparam logic [CntW-1:0] DrainLast  = CntW'(DRAIN_TIMEOUT - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SettleLen - 1);
    localparam logic [CntW-1:0] WakeLast   = CntW'(WakeLen - 1);
    localparam logic [CntW-1:0] CntSat     = {CntW{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StSettle,
        StSleep,
        StWake
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fe_q, fe_d;
    logic            abort_q, abort_d;
    logic            timeout_q, timeout_d;
    logic            wake_evt;
    logic            busy_any;

    assign wake_evt = bus.wake_i | bus.debug_req_i;
    assign busy_any = bus.if_busy_i | bus.ctrl_busy_i | bus.lsu_busy_i | bus.apu_busy_i;

    always_comb begin
        state_d   = state_q;
        abort_d   = 1'b0;
        timeout_d = timeout_q;
        fe_d      = fe_q | bus.fetch_enable_i;

        unique case (state_q)
            StIdle: begin
                if (fe_q) state_d = StRun;
            end
            StRun: begin
                if (bus.sleep_req_i) begin
                    if (wake_evt) abort_d = 1'b1;
                    else          state_d = StDrain;
                end
            end
            StDrain: begin
                if (wake_evt) begin
                    state_d = StRun;
                    abort_d = 1'b1;
                end else if (busy_any && (cnt_q == DrainLast)) begin
                    state_d   = StRun;
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (!busy_any) begin
                    state_d = (SETTLE_CYCLES == 0) ? StSleep : StSettle;
                end
            end
            StSettle: begin
                if (wake_evt) begin
                    state_d = StRun;
                    abort_d = 1'b1;
                end else if (busy_any) begin
                    state_d = StDrain;
                end else if (cnt_q == SettleLast) begin
                    state_d = StSleep;
                end
            end
            StSleep: begin
                // Only wake/debug are observed while gated.
                if (wake_evt) state_d = StWake;
            end
            StWake: begin
                if (cnt_q == WakeLast) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase

        // Shared counter restarts on every state entry, otherwise saturates.
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == CntSat) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fe_q      <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fe_q      <= fe_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
        end
    end

    // Enable rises combinationally on wake so the very next gated edge happens.
    assign bus.clock_en_o      = (state_q == StRun) || (state_q == StDrain) ||
                                 (state_q == StSettle) || (state_q == StWake) ||
                                 ((state_q == StSleep) && wake_evt);
    assign bus.core_sleep_o    = (state_q == StSleep) && !wake_evt;
    assign bus.wake_o          = (state_q == StWake) && (cnt_q == WakeLast);
    assign bus.fetch_enable_o  = fe_q;
    assign bus.sleep_abort_o   = abort_q;
    assign bus.drain_timeout_o = timeout_q;

`ifdef CV32E40P_SLEEP_STATS_EN
    logic [31:0] sleep_cycles_q, sleep_cycles_d;
    logic [15:0] sleep_count_q, sleep_count_d;

    always_comb begin
        sleep_cycles_d = sleep_cycles_q;
        sleep_count_d  = sleep_count_q;
        if ((state_q == StSleep) && (sleep_cycles_q != 32'hFFFF_FFFF)) begin
            sleep_cycles_d = sleep_cycles_q + 32'd1;
        end
        if ((state_d == StSleep) && (state_q != StSleep)) begin
            sleep_count_d = sleep_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sleep_cycles_q <= '0;
            sleep_count_q  <= '0;
        end else begin
            sleep_cycles_q <= sleep_cycles_d;
            sleep_count_q  <= sleep_count_d;
        end
    end

    assign sleep_cycles_o = sleep_cycles_q;
    assign sleep_count_o  = sleep_count_q;
`endif
endmodule
